// File: rtl/rx_byte_align_pkg.sv
// Shared Rx/Tx symbol constants and receive-alignment state encoding.
package rx_byte_align_pkg;

    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_IDLE = 8'h7C;

    typedef logic [1:0] state_t;

    localparam state_t ST_HUNT   = 2'd0;
    localparam state_t ST_VERIFY = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/rx_byte_align_shift8.sv
// 8-bit MSB-first input shift register; cand is the byte completed at the current edge.
module rx_shift8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       serial_in,
    output logic [7:0] cand
);

    logic [7:0] sreg;

    assign cand = {sreg[6:0], serial_in};

    // Shift one bit per enabled edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= 8'd0;
        end else if (enb) begin
            sreg <= cand;
        end else begin
            sreg <= sreg;
        end
    end

endmodule

// File: rtl/rx_byte_align.sv
// Recovers byte boundaries from a serial stream by hunting for COM, then strobes bytes every 8 enabled bits.
module rx_byte_align
    import rx_byte_align_pkg::*;
#(
    parameter logic [7:0] COM     = SYM_COM,
    parameter int          COM_REQ = 2,
    parameter int          MAX_GAP = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       serial_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       is_com,
    output logic       locked
);

    localparam logic [3:0] COM_REQ_W = 4'(COM_REQ);
    localparam logic [7:0] MAX_GAP_W = 8'(MAX_GAP);

    logic [7:0] cand;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] gap_cnt;
    state_t     state;

    logic       cand_is_com;
    logic       boundary;
    logic [3:0] com_inc;
    logic [7:0] gap_inc;

    rx_shift8 u_shift (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .serial_in (serial_in),
        .cand      (cand)
    );

    assign cand_is_com = (cand == COM);
    assign boundary    = (bit_cnt == 3'd7);
    assign com_inc     = com_cnt + 4'd1;
    assign gap_inc     = gap_cnt + 8'd1;

    // Alignment FSM, counters and registered byte outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            com_cnt    <= 4'd0;
            gap_cnt    <= 8'd0;
            state      <= ST_HUNT;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            is_com     <= 1'b0;
            locked     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            is_com     <= 1'b0;
            if (enb) begin
                bit_cnt <= bit_cnt + 3'd1;
                case (state)
                    ST_HUNT: begin
                        if (cand_is_com) begin
                            bit_cnt <= 3'd0;
                            com_cnt <= 4'd1;
                            if (COM_REQ == 1) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= ST_VERIFY;
                            end
                        end else begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_VERIFY: begin
                        if (!boundary) begin
                            state <= ST_VERIFY;
                        end else if (!cand_is_com) begin
                            // A failed verify edge is not reused as a new hunt candidate
                            state   <= ST_HUNT;
                            com_cnt <= 4'd0;
                            gap_cnt <= 8'd0;
                        end else if (com_inc == COM_REQ_W) begin
                            com_cnt    <= com_inc;
                            state      <= ST_LOCKED;
                            locked     <= 1'b1;
                            gap_cnt    <= 8'd0;
                            byte_out   <= cand;
                            byte_valid <= 1'b1;
                            is_com     <= 1'b1;
                        end else begin
                            com_cnt <= com_inc;
                        end
                    end
                    ST_LOCKED: begin
                        if (boundary) begin
                            byte_out   <= cand;
                            byte_valid <= 1'b1;
                            is_com     <= cand_is_com;
                            if (cand_is_com) begin
                                gap_cnt <= 8'd0;
                            end else if (gap_inc == MAX_GAP_W) begin
                                state   <= ST_HUNT;
                                locked  <= 1'b0;
                                gap_cnt <= 8'd0;
                                com_cnt <= 4'd0;
                            end else begin
                                gap_cnt <= gap_inc;
                            end
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end
                    default: begin
                        state   <= ST_HUNT;
                        locked  <= 1'b0;
                        com_cnt <= 4'd0;
                        gap_cnt <= 8'd0;
                    end
                endcase
            end else begin
                bit_cnt <= bit_cnt;
            end
        end
    end

endmodule
